pipe_stage_reg: RTL and testbench

Generic, parametrised pipeline stage register for the CPU datapath. It is the successor to the fixed stall-vector stage registers. It replaces the global stall vector with a per-stage valid/ready handshake and keeps a synchronous flush. An optional skid entry gives full throughput with a registered in_ready. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), carrying an opaque packed payload.

---
 rtl/pipe_stage_reg_pkg.sv | 29 ++
 rtl/pipe_stage_reg_sat_counter.sv | 30 +++
 rtl/pipe_stage_reg.sv | 133 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared types and constants for pipeline stage registers
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    localparam int PSR_DATA_W_DEF = 128;
    localparam int PSR_CNT_W_DEF  = 16;
    localparam logic [PSR_DATA_W_DEF-1:0] PSR_NOP = '0;

    // ID/EX payload field LSB positions, packed by the instantiating stage
    localparam int IDEX_ALUOP_LSB      = 0;
    localparam int IDEX_ALUSEL_LSB     = 8;
    localparam int IDEX_REG1_LSB       = 11;
    localparam int IDEX_REG2_LSB       = 43;
    localparam int IDEX_WD_LSB         = 75;
    localparam int IDEX_WREG_LSB       = 80;
    localparam int IDEX_LINK_ADDR_LSB  = 81;
    localparam int IDEX_IN_DSLOT_LSB   = 113;
    localparam int IDEX_NEXT_DSLOT_LSB = 114;

    function automatic logic [1:0] state_occ(input state_e s);
        return {s == ST_SKID, s == ST_FULL};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// rtl/pipe_stage_reg_sat_counter.sv - saturating event counter
module pipe_stage_reg_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional skid entry
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W    = PSR_DATA_W_DEF,
    parameter bit                SKID      = 1'b1,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                CNT_W     = PSR_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire, out_fire;
    logic              bubble_inc, stall_inc;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_occ(state_q);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    generate
        if (SKID) begin : g_skid
            logic [DATA_W-1:0] skid_r_q, skid_r_d;

            // Registered ready: the skid entry absorbs the word accepted while downstream stalls
            assign in_ready = (state_q != ST_SKID);
            assign skid_q   = skid_r_q;

            always_comb begin
                skid_r_d = skid_r_q;
                if (flush) begin
                    skid_r_d = NOP_VALUE;
                end else if ((state_q == ST_FULL) && in_fire && !out_fire) begin
                    skid_r_d = in_data;
                end else if ((state_q == ST_SKID) && out_fire) begin
                    skid_r_d = NOP_VALUE;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    skid_r_q <= NOP_VALUE;
                end else begin
                    skid_r_q <= skid_r_d;
                end
            end
        end else begin : g_no_skid
            assign in_ready = !out_valid || out_ready;
            assign skid_q   = NOP_VALUE;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_FULL;
                        main_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = NOP_VALUE;
                    end else if (in_fire) begin
                        state_d = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    assign bubble_inc = !out_valid && out_ready;
    assign stall_inc  = out_valid && !out_ready;

    pipe_stage_reg_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bubble_inc),
        .cnt (bubble_cnt)
    );

    pipe_stage_reg_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - skid and no-skid stage registers against a queue model
module tb_pipe_stage_reg;

    localparam int              DW  = 16;
    localparam logic [DW-1:0]   NOP = 16'h5A5A;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;

    logic          ir [2];
    logic          ov [2];
    logic [DW-1:0] od [2];
    logic [1:0]    oc [2];
    logic [3:0]    bc_s, sc_s;
    logic [15:0]   bc_n, sc_n;

    logic [DW-1:0] mq [2][$];
    int            mbub [2];
    int            mstl [2];
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1), .NOP_VALUE(NOP), .CNT_W(4)) u_dut_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .occupancy(oc[0]), .bubble_cnt(bc_s), .stall_cnt(sc_s)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(1'b0), .NOP_VALUE(NOP), .CNT_W(16)) u_dut_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .occupancy(oc[1]), .bubble_cnt(bc_n), .stall_cnt(sc_n)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_in_ready(input int i);
        if (i == 0) return mq[0].size() < 2;
        return (mq[1].size() == 0) || out_ready;
    endfunction

    function automatic logic [DW-1:0] m_out_data(input int i);
        if (mq[i].size() > 0) return mq[i][0];
        return NOP;
    endfunction

    task automatic check_all(input int i);
        string nm;
        logic [15:0] bc, sc;
        nm = (i == 0) ? "skid" : "noskid";
        bc = (i == 0) ? {12'b0, bc_s} : bc_n;
        sc = (i == 0) ? {12'b0, sc_s} : sc_n;
        chk_eq({nm, "_in_ready"},  32'(ir[i]), 32'(m_in_ready(i)));
        chk_eq({nm, "_out_valid"}, 32'(ov[i]), 32'(mq[i].size() > 0));
        chk_eq({nm, "_out_data"},  32'(od[i]), 32'(m_out_data(i)));
        chk_eq({nm, "_occupancy"}, 32'(oc[i]), 32'(mq[i].size()));
        chk_eq({nm, "_bubble"},    32'(bc),    32'(mbub[i]));
        chk_eq({nm, "_stall"},     32'(sc),    32'(mstl[i]));
    endtask

    // Inputs are already applied; check, then advance one clock and the model with it
    task automatic tick(input bit do_chk);
        bit inf [2];
        bit outf [2];
        int cmax;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (do_chk) check_all(i);
            inf[i]  = in_valid && m_in_ready(i);
            outf[i] = (mq[i].size() > 0) && out_ready;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            cmax = (i == 0) ? 15 : 65535;
            if (rst) begin
                mq[i].delete();
                mbub[i] = 0;
                mstl[i] = 0;
            end else begin
                if ((mq[i].size() == 0) && out_ready && (mbub[i] < cmax)) mbub[i]++;
                if ((mq[i].size() > 0) && !out_ready && (mstl[i] < cmax)) mstl[i]++;
                if (outf[i]) void'(mq[i].pop_front());
                if (inf[i]) mq[i].push_back(in_data);
                if (flush) mq[i].delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit f, input bit v, input logic [DW-1:0] d, input bit o);
        rst       = r;
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = o;
    endtask

    initial begin
        logic [15:0] sc_before;

        drive(1, 0, 0, 16'h0, 1);
        tick(0);
        tick(1);

        drive(0, 0, 1, 16'h00A5, 1);
        tick(1);
        chk_eq("t1_valid", 32'(ov[0]), 32'd1);
        chk_eq("t1_data",  32'(od[0]), 32'h00A5);
        chk_eq("t1_occ",   32'(oc[0]), 32'd1);
        drive(0, 0, 0, 16'h0, 1);
        tick(1);
        chk_eq("t1_drain_valid", 32'(ov[0]), 32'd0);
        chk_eq("t1_drain_data",  32'(od[0]), 32'(NOP));

        for (int k = 1; k <= 3; k++) begin
            drive(0, 0, 1, 16'(k), 0);
            tick(1);
        end
        chk_eq("t2_in_ready", 32'(ir[0]), 32'd0);
        chk_eq("t2_occ",      32'(oc[0]), 32'd2);
        chk_eq("t2_main",     32'(od[0]), 32'h1);
        drive(0, 0, 1, 16'h3, 1);
        tick(1);
        chk_eq("t2_out2", 32'(od[0]), 32'h2);
        tick(1);
        drive(0, 0, 0, 16'h0, 1);
        chk_eq("t2_out3", 32'(od[0]), 32'h3);
        tick(1);
        chk_eq("t2_empty", 32'(ov[0]), 32'd0);

        drive(0, 0, 1, 16'h7, 0);
        tick(1);
        drive(0, 0, 0, 16'h0, 0);
        tick(1);
        drive(0, 1, 1, 16'h9, 0);
        tick(1);
        drive(0, 0, 0, 16'h0, 1);
        chk_eq("t3_valid", 32'(ov[0]), 32'd0);
        chk_eq("t3_occ",   32'(oc[0]), 32'd0);
        chk_eq("t3_data",  32'(od[0]), 32'(NOP));
        tick(1);
        chk_eq("t3_no_9", 32'(ov[0]), 32'd0);

        sc_before = sc_n;
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 1, 16'(16'h100 + k), (k % 2) == 0);
            tick(1);
        end
        chk_eq("t4_stall_delta", 32'(sc_n - sc_before), 32'd4);

        drive(1, 0, 0, 16'h0, 1);
        tick(1);
        drive(0, 0, 0, 16'h0, 1);
        for (int k = 0; k < 20; k++) tick(1);
        chk_eq("t5_bubble_sat", 32'(bc_s), 32'd15);
        drive(1, 0, 0, 16'h0, 1);
        tick(1);
        chk_eq("t5_bubble_rst", 32'(bc_s), 32'd0);

        drive(0, 0, 1, 16'h0033, 0);
        tick(1);
        drive(0, 0, 1, 16'h0044, 0);
        tick(1);
        chk_eq("t6_occ_skid", 32'(oc[0]), 32'd2);
        drive(1, 0, 1, 16'h0055, 0);
        tick(1);
        chk_eq("t6_occ",      32'(oc[0]), 32'd0);
        chk_eq("t6_valid",    32'(ov[0]), 32'd0);
        chk_eq("t6_in_ready", 32'(ir[0]), 32'd1);
        chk_eq("t6_data",     32'(od[0]), 32'(NOP));

        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(63) == 0, $urandom_range(15) == 0,
                  $urandom_range(3) != 0, 16'($urandom), $urandom_range(2) != 0);
            tick(1);
        end
        drive(0, 0, 0, 16'h0, 1);
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
